// File: rtl/lsu_sequencer.sv
// lsu_sequencer: runs one request/grant/response bus transaction per
// load/store, stalls the core while it is in flight, builds byte enables,
// lane-replicates store data and extends load data. Rejects illegal or
// misaligned accesses without touching the bus and aborts on bus timeout.
//
// Bus handshake: mem_req is high only in REQ, and mem_we, mem_addr, mem_be
// and mem_wdata are held stable from registers until mem_gnt is seen high
// at a rising edge. For loads, mem_rvalid is only honoured in WAIT; a
// response in any other state is dropped.
module lsu_sequencer #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_op,
    input  logic        store_op,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        misaligned,
    output logic        bus_error,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic [1:0]  fsm_state
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic          lat_load;
    logic [2:0]    lat_f3;
    logic [1:0]    lat_off;
    logic          err;

    logic          access, legal, start, last, timeout;
    logic [3:0]    be_c;
    logic [31:0]   wd_c;

    // Pick the addressed byte/halfword and extend it according to funct3.
    function automatic logic [31:0] extract(input logic [2:0] f3,
                                            input logic [1:0] off,
                                            input logic [31:0] w);
        logic [31:0] sh;
        logic [15:0] hw;
        sh = w >> {off, 3'b000};
        hw = off[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  return {{24{sh[7]}}, sh[7:0]};
            3'b001:  return {{16{hw[15]}}, hw};
            3'b100:  return {24'h0, sh[7:0]};
            3'b101:  return {16'h0, hw};
            default: return w;
        endcase
    endfunction

    // Legality of the presented access; load wins when both strobes are high.
    always_comb begin
        legal = 1'b0;
        case (funct3)
            3'b000:  legal = 1'b1;
            3'b001:  legal = ~addr[0];
            3'b010:  legal = (addr[1:0] == 2'b00);
            3'b100:  legal = load_op;
            3'b101:  legal = load_op & ~addr[0];
            default: legal = 1'b0;
        endcase
    end

    assign access  = load_op | store_op;
    assign start   = (state == S_IDLE) & access & legal;
    assign last    = (cnt == CW'(TIMEOUT - 1));
    assign timeout = ((state == S_REQ)  & ~mem_gnt    & last) |
                     ((state == S_WAIT) & ~mem_rvalid & last);

    // Byte enables and lane-replicated store data from size and offset.
    always_comb begin
        be_c = 4'b1111;
        wd_c = wdata;
        case (funct3[1:0])
            2'b00: begin
                be_c = 4'b0001 << addr[1:0];
                wd_c = {4{wdata[7:0]}};
            end
            2'b01: begin
                be_c = addr[1] ? 4'b1100 : 4'b0011;
                wd_c = {2{wdata[15:0]}};
            end
            default: begin
                be_c = 4'b1111;
                wd_c = wdata;
            end
        endcase
    end

    // Next-state logic; a grant or response on the final counted cycle wins over timeout.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = S_REQ;
            S_REQ: begin
                if (mem_gnt)   state_nxt = lat_load ? S_WAIT : S_DONE;
                else if (last) state_nxt = S_DONE;
            end
            S_WAIT: begin
                if (mem_rvalid) state_nxt = S_DONE;
                else if (last)  state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register, access latch, timeout counter and load result register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            lat_load  <= 1'b0;
            lat_f3    <= 3'b000;
            lat_off   <= 2'b00;
            err       <= 1'b0;
            rdata     <= 32'h0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'h0;
            mem_be    <= 4'h0;
            mem_wdata <= 32'h0;
        end else begin
            state <= state_nxt;
            if (start) begin
                cnt       <= '0;
                err       <= 1'b0;
                lat_load  <= load_op;
                lat_f3    <= funct3;
                lat_off   <= addr[1:0];
                mem_we    <= ~load_op;
                mem_addr  <= {addr[31:2], 2'b00};
                mem_be    <= be_c;
                mem_wdata <= wd_c;
            end else if (state == S_REQ || state == S_WAIT) begin
                cnt <= cnt + CW'(1);
            end
            if (state == S_WAIT && mem_rvalid) begin
                rdata <= extract(lat_f3, lat_off, mem_rdata);
            end
            if (timeout) begin
                rdata <= 32'h0;
                err   <= 1'b1;
            end
        end
    end

    assign stall       = start | (state == S_REQ) | (state == S_WAIT);
    assign mem_req     = (state == S_REQ);
    assign rdata_valid = (state == S_DONE) & lat_load & ~err;
    assign bus_error   = (state == S_DONE) & err;
    assign misaligned  = rst_n & (state == S_IDLE) & access & ~legal;
    assign fsm_state   = state;

endmodule

// File: tb/tb_lsu_sequencer.sv
// Directed bench for lsu_sequencer: loads of every size, stores, illegal
// accesses, a bus timeout and a reset in the middle of a load. Expected load
// results are queued when the access is issued and popped on rdata_valid.
module tb_lsu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_op = 1'b0, store_op = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = 32'h0, wdata = 32'h0;
    logic        stall, rdata_valid, misaligned, bus_error;
    logic [31:0] rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic [1:0]  fsm_state;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    lsu_sequencer #(.TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .load_op(load_op), .store_op(store_op),
        .funct3(funct3), .addr(addr), .wdata(wdata), .stall(stall),
        .rdata(rdata), .rdata_valid(rdata_valid), .misaligned(misaligned),
        .bus_error(bus_error), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .fsm_state(fsm_state)
    );

    // Clock generation.
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 ns after the rising edge; outputs are sampled at the falling edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    function automatic logic [31:0] ref_ext(input logic [2:0] f3, input logic [1:0] off,
                                            input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[8*int'(off) +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'h0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'h0, h};
            default: return w;
        endcase
    endfunction

    function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b00:   return 4'b0001 << off;
            2'b01:   return off[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    task automatic check_reset(input string p);
        chk({p, "_mem_req"},     mem_req,     0);
        chk({p, "_mem_we"},      mem_we,      0);
        chk({p, "_mem_be"},      mem_be,      0);
        chk({p, "_rdata_valid"}, rdata_valid, 0);
        chk({p, "_misaligned"},  misaligned,  0);
        chk({p, "_bus_error"},   bus_error,   0);
        chk({p, "_rdata"},       rdata,       0);
        chk({p, "_mem_addr"},    mem_addr,    0);
        chk({p, "_mem_wdata"},   mem_wdata,   0);
        chk({p, "_state"},       fsm_state,   0);
    endtask

    // Issue a load, grant after gd cycles, respond after rd more cycles.
    task automatic do_load(input string t, input logic both, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] word,
                           input logic [3:0] exp_be, input int gd, input int rd,
                           input logic [31:0] exp_data);
        exp_q.push_back(exp_data);
        load_op = 1'b1; store_op = both; funct3 = f3; addr = a; wdata = $urandom;
        mid();
        chk({t, "_c0_stall"}, stall, 1);
        chk({t, "_c0_req"}, mem_req, 0);
        step();
        for (int i = 0; i <= gd; i++) begin
            mem_gnt = (i == gd);
            mid();
            chk({t, "_req"}, mem_req, 1);
            chk({t, "_we"}, mem_we, 0);
            chk({t, "_addr"}, mem_addr, {a[31:2], 2'b00});
            chk({t, "_be"}, mem_be, exp_be);
            chk({t, "_req_stall"}, stall, 1);
            step();
        end
        mem_gnt = 1'b0;
        for (int i = 0; i <= rd; i++) begin
            mem_rvalid = (i == rd);
            mem_rdata = (i == rd) ? word : $urandom;
            mid();
            chk({t, "_wait_req"}, mem_req, 0);
            chk({t, "_wait_stall"}, stall, 1);
            step();
        end
        mem_rvalid = 1'b0; mem_rdata = $urandom; load_op = 1'b0; store_op = 1'b0;
        mid();
        chk({t, "_done_stall"}, stall, 0);
        chk({t, "_rdata_valid"}, rdata_valid, 1);
        if (rdata_valid && exp_q.size() > 0) chk({t, "_rdata"}, rdata, exp_q.pop_front());
        step();
        mid();
        chk({t, "_after_valid"}, rdata_valid, 0);
        chk({t, "_after_state"}, fsm_state, 0);
        step();
    endtask

    task automatic do_store(input string t, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd, input logic [3:0] exp_be,
                            input logic [31:0] exp_wd, input int gd);
        store_op = 1'b1; funct3 = f3; addr = a; wdata = wd;
        mid();
        chk({t, "_c0_stall"}, stall, 1);
        step();
        for (int i = 0; i <= gd; i++) begin
            mem_gnt = (i == gd);
            mid();
            chk({t, "_req"}, mem_req, 1);
            chk({t, "_we"}, mem_we, 1);
            chk({t, "_addr"}, mem_addr, {a[31:2], 2'b00});
            chk({t, "_be"}, mem_be, exp_be);
            chk({t, "_wdata"}, mem_wdata, exp_wd);
            step();
        end
        mem_gnt = 1'b0; store_op = 1'b0;
        mid();
        chk({t, "_done_stall"}, stall, 0);
        chk({t, "_done_req"}, mem_req, 0);
        chk({t, "_done_valid"}, rdata_valid, 0);
        chk({t, "_done_state"}, fsm_state, 3);
        step();
    endtask

    task automatic do_bad(input string t, input logic ld, input logic [2:0] f3,
                          input logic [31:0] a);
        load_op = ld; store_op = ~ld; funct3 = f3; addr = a;
        mid();
        chk({t, "_misaligned"}, misaligned, 1);
        chk({t, "_stall"}, stall, 0);
        chk({t, "_req"}, mem_req, 0);
        step();
        load_op = 1'b0; store_op = 1'b0;
        mid();
        chk({t, "_mis_clear"}, misaligned, 0);
        chk({t, "_req_after"}, mem_req, 0);
        chk({t, "_state"}, fsm_state, 0);
        step();
    endtask

    initial begin
        // Reset.
        step(); step();
        mid();
        check_reset("rst");
        step();
        rst_n = 1'b1;
        step();

        // Directed loads.
        do_load("lw",  1'b0, 3'b010, 32'h100, 32'hDEADBEEF, 4'b1111, 0, 0, 32'hDEADBEEF);
        do_load("lb",  1'b0, 3'b000, 32'h103, 32'h80FF7F01, 4'b1000, 0, 0, 32'hFFFFFF80);
        do_load("lbu", 1'b0, 3'b100, 32'h103, 32'h80FF7F01, 4'b1000, 1, 0, 32'h00000080);
        do_load("lh",  1'b0, 3'b001, 32'h102, 32'h80FF7F01, 4'b1100, 0, 1, 32'hFFFF80FF);
        do_load("lhu", 1'b0, 3'b101, 32'h102, 32'h80FF7F01, 4'b1100, 1, 1, 32'h000080FF);
        do_load("both", 1'b1, 3'b010, 32'h180, 32'h13572468, 4'b1111, 0, 0, 32'h13572468);

        // Directed stores.
        do_store("sb", 3'b000, 32'h201, 32'h000000A5, 4'b0010, 32'hA5A5A5A5, 0);
        do_store("sh", 3'b001, 32'h202, 32'h00001234, 4'b1100, 32'h12341234, 1);
        do_store("sw", 3'b010, 32'h204, 32'hCAFEF00D, 4'b1111, 32'hCAFEF00D, 0);

        // Illegal accesses.
        do_bad("lw_mis", 1'b1, 3'b010, 32'h102);
        do_bad("sh_mis", 1'b0, 3'b001, 32'h101);
        do_bad("sbu_bad", 1'b0, 3'b100, 32'h100);
        do_bad("f3_bad", 1'b1, 3'b011, 32'h100);

        // Randomised legal loads checked against the reference extractor.
        for (int k = 0; k < 6; k++) begin
            logic [2:0]  f3s [5];
            logic [2:0]  f3;
            logic [1:0]  off;
            logic [31:0] a, w;
            f3s = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
            f3 = f3s[$urandom_range(0, 4)];
            off = 2'($urandom_range(0, 3));
            if (f3[0]) off[0] = 1'b0;
            if (f3[1]) off = 2'b00;
            a = {20'h00001, 10'($urandom_range(0, 1023)), off};
            w = $urandom;
            do_load("rnd", 1'b0, f3, a, w, ref_be(f3, off),
                    $urandom_range(0, 1), $urandom_range(0, 1), ref_ext(f3, off, w));
        end

        // Timeout: grant never arrives.
        load_op = 1'b1; funct3 = 3'b010; addr = 32'h300;
        mid();
        chk("to_c0_stall", stall, 1);
        step();
        for (int i = 0; i < 4; i++) begin
            mid();
            chk("to_req_high", mem_req, 1);
            step();
        end
        load_op = 1'b0;
        mid();
        chk("to_req_drop", mem_req, 0);
        chk("to_bus_error", bus_error, 1);
        chk("to_no_valid", rdata_valid, 0);
        chk("to_rdata_zero", rdata, 0);
        chk("to_stall", stall, 0);
        step();
        mid();
        chk("to_err_clear", bus_error, 0);
        chk("to_state", fsm_state, 0);
        step();

        // Reset while waiting for the load response; response arrives late.
        load_op = 1'b1; funct3 = 3'b010; addr = 32'h400;
        step();
        mem_gnt = 1'b1;
        mid();
        chk("mr_req", mem_req, 1);
        step();
        mem_gnt = 1'b0; rst_n = 1'b0;
        mid();
        chk("mr_wait_state", fsm_state, 2);
        step();
        rst_n = 1'b1; load_op = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h5555AAAA;
        mid();
        check_reset("mr");
        chk("mr_stall", stall, 0);
        step();
        mem_rvalid = 1'b0;
        mid();
        chk("mr_late_valid", rdata_valid, 0);
        chk("mr_late_req", mem_req, 0);
        chk("mr_late_state", fsm_state, 0);
        step();

        chk("queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
